// File: rtl/affine_pkg.sv
// Shared types and constants for the affine coordinate pipeline.
// Q16.16 fixed point, coefficient word offsets and the generator FSM states.
package affine_pkg;

  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] q16_t;

  localparam logic [2:0] COEF_A  = 3'd0;
  localparam logic [2:0] COEF_B  = 3'd1;
  localparam logic [2:0] COEF_TX = 3'd2;
  localparam logic [2:0] COEF_C  = 3'd3;
  localparam logic [2:0] COEF_D  = 3'd4;
  localparam logic [2:0] COEF_TY = 3'd5;

  // One extra fetch slot drains the last read word.
  localparam logic [2:0] FETCH_LAST = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    INIT,
    RUN,
    DONE
  } state_t;

  // Integer part of a Q16.16 value, still signed.
  function automatic logic signed [15:0] q16_int(input q16_t v);
    return v[31:FRAC_BITS];
  endfunction

endpackage

// File: rtl/affine_bounds_check.sv
// Combinational Q16.16 bounds test against a source image size.
// Negative integer parts are always out of bounds.
module affine_bounds_check
  import affine_pkg::*;
#(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480
) (
  input  q16_t x,
  input  q16_t y,
  output logic in_bounds
);

  logic signed [15:0] xi;
  logic signed [15:0] yi;
  logic               x_ok;
  logic               y_ok;

  assign xi = q16_int(x);
  assign yi = q16_int(y);

  assign x_ok = (xi >= 16'sd0) &&
                (int'(xi) < SRC_WIDTH);
  assign y_ok = (yi >= 16'sd0) &&
                (int'(yi) < SRC_HEIGHT);

  assign in_bounds = x_ok && y_ok;

endmodule

// File: rtl/affine_coord_gen.sv
// Fetches a 2x3 affine matrix from RAM, then streams the mapped
// source coordinate of every destination pixel in raster order.
module affine_coord_gen
  import affine_pkg::*;
#(
  parameter int DST_WIDTH  = 640,
  parameter int DST_HEIGHT = 480,
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int BASE_ADDR  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [9:0]  mem_address,
  output logic        mem_chipselect,
  input  logic [31:0] mem_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_src_x,
  output logic [31:0] out_src_y,
  output logic        out_in_bounds,
  output logic        out_sop,
  output logic        out_eop
);

  localparam logic [11:0] LAST_COL = 12'(DST_WIDTH - 1);
  localparam logic [11:0] LAST_ROW = 12'(DST_HEIGHT - 1);
  localparam logic [9:0]  BASE     = 10'(BASE_ADDR);
  localparam logic        ONE_PIX  =
    (LAST_COL == 12'd0) && (LAST_ROW == 12'd0);

  state_t      state;
  logic [2:0]  k;

  q16_t        coef_a;
  q16_t        coef_b;
  q16_t        coef_tx;
  q16_t        coef_c;
  q16_t        coef_d;
  q16_t        coef_ty;

  q16_t        row_x;
  q16_t        row_y;
  q16_t        cur_x;
  q16_t        cur_y;
  logic [11:0] col;
  logic [11:0] row;

  logic        fire;
  logic        last_col;
  logic        last_row;
  logic [11:0] nxt_col;
  logic [11:0] nxt_row;

  assign fire     = out_valid & out_ready;
  assign last_col = (col == LAST_COL);
  assign last_row = (row == LAST_ROW);

  assign out_src_x = cur_x;
  assign out_src_y = cur_y;

  // Raster position after the current pixel is accepted.
  always_comb begin
    nxt_col = col + 12'd1;
    nxt_row = row;
    if (last_col) begin
      nxt_col = 12'd0;
      nxt_row = row + 12'd1;
    end
  end

  // Latch coefficient k-1; its read data arrives one cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_a  <= '0;
      coef_b  <= '0;
      coef_tx <= '0;
      coef_c  <= '0;
      coef_d  <= '0;
      coef_ty <= '0;
    end else if (state == FETCH) begin
      unique case (k)
        COEF_A  + 3'd1: coef_a  <= mem_readdata;
        COEF_B  + 3'd1: coef_b  <= mem_readdata;
        COEF_TX + 3'd1: coef_tx <= mem_readdata;
        COEF_C  + 3'd1: coef_c  <= mem_readdata;
        COEF_D  + 3'd1: coef_d  <= mem_readdata;
        COEF_TY + 3'd1: coef_ty <= mem_readdata;
        default: ;
      endcase
    end
  end

  // Frame sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      k              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      out_valid      <= 1'b0;
      out_sop        <= 1'b0;
      out_eop        <= 1'b0;
      col            <= '0;
      row            <= '0;
      row_x          <= '0;
      row_y          <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= FETCH;
            k              <= '0;
            busy           <= 1'b1;
            mem_chipselect <= 1'b1;
            mem_address    <= BASE;
          end
        end

        FETCH: begin
          if (k == FETCH_LAST) begin
            state <= INIT;
          end else begin
            k              <= k + 3'd1;
            mem_chipselect <= (k < COEF_TY);
            mem_address    <= BASE +
                              {7'd0, k + 3'd1};
          end
        end

        INIT: begin
          col       <= '0;
          row       <= '0;
          row_x     <= coef_tx;
          row_y     <= coef_ty;
          cur_x     <= coef_tx;
          cur_y     <= coef_ty;
          out_valid <= 1'b1;
          out_sop   <= 1'b1;
          out_eop   <= ONE_PIX;
          state     <= RUN;
        end

        RUN: begin
          if (fire) begin
            if (last_col && last_row) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_sop   <= 1'b0;
              out_eop   <= 1'b0;
              done      <= 1'b1;
            end else begin
              col     <= nxt_col;
              row     <= nxt_row;
              out_sop <= 1'b0;
              out_eop <= (nxt_col == LAST_COL) &&
                         (nxt_row == LAST_ROW);
              if (!last_col) begin
                cur_x <= cur_x + coef_a;
                cur_y <= cur_y + coef_c;
              end else begin
                row_x <= row_x + coef_b;
                row_y <= row_y + coef_d;
                cur_x <= row_x + coef_b;
                cur_y <= row_y + coef_d;
              end
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  affine_bounds_check #(
    .SRC_WIDTH (SRC_WIDTH),
    .SRC_HEIGHT(SRC_HEIGHT)
  ) u_bounds (
    .x        (cur_x),
    .y        (cur_y),
    .in_bounds(out_in_bounds)
  );

endmodule

// File: tb/tb_affine_coord_gen.sv
// Scoreboard bench for affine_coord_gen: a 4x2 instance for the
// directed cases and a 16x4 instance for random backpressure.
module tb_affine_coord_gen;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        inb;
    logic        sop;
    logic        eop;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic        busy_a, busy_b, done_a, done_b;
  logic [9:0]  addr_a, addr_b;
  logic        cs_a, cs_b;
  logic [31:0] rd_a, rd_b;
  logic        valid_a, valid_b;
  logic        ready_a = 1'b1, ready_b = 1'b1;
  logic [31:0] x_a, y_a, x_b, y_b;
  logic        inb_a, inb_b, sop_a, sop_b, eop_a, eop_b;

  logic [31:0] mem [0:1023];
  logic [9:0]  ra_a = '0, ra_b = '0;

  always @(posedge clk) begin
    if (cs_a) ra_a <= addr_a;
    if (cs_b) ra_b <= addr_b;
  end
  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];

  affine_coord_gen #(
    .DST_WIDTH(4), .DST_HEIGHT(2),
    .SRC_WIDTH(4), .SRC_HEIGHT(2),
    .BASE_ADDR(0)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .busy(busy_a), .done(done_a),
    .mem_address(addr_a), .mem_chipselect(cs_a),
    .mem_readdata(rd_a),
    .out_valid(valid_a), .out_ready(ready_a),
    .out_src_x(x_a), .out_src_y(y_a),
    .out_in_bounds(inb_a),
    .out_sop(sop_a), .out_eop(eop_a)
  );

  affine_coord_gen #(
    .DST_WIDTH(16), .DST_HEIGHT(4),
    .SRC_WIDTH(640), .SRC_HEIGHT(480),
    .BASE_ADDR(16)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(busy_b), .done(done_b),
    .mem_address(addr_b), .mem_chipselect(cs_b),
    .mem_readdata(rd_b),
    .out_valid(valid_b), .out_ready(ready_b),
    .out_src_x(x_b), .out_src_y(y_b),
    .out_in_bounds(inb_b),
    .out_sop(sop_b), .out_eop(eop_b)
  );

  int   n_checks = 0;
  int   n_err = 0;
  exp_t qa[$], qb[$];
  exp_t cap_a[256], cap_b[256];
  int   pop_a = 0, pop_b = 0;
  int   done_cnt_a = 0, done_cnt_b = 0;
  bit   pend_done_a = 0, pend_done_b = 0;
  bit   stall_a = 0, stall_b = 0;
  exp_t held_a, held_b;
  bit   rand_b = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic cmp_pix(input string tag,
                         input exp_t act,
                         input exp_t exp);
    chk({tag, "_x"}, act.x, exp.x);
    chk({tag, "_y"}, act.y, exp.y);
    chk({tag, "_inb"}, 32'(act.inb), 32'(exp.inb));
    chk({tag, "_sop"}, 32'(act.sop), 32'(exp.sop));
    chk({tag, "_eop"}, 32'(act.eop), 32'(exp.eop));
  endtask

  // Monitor for the 4x2 instance.
  always @(negedge clk) begin
    exp_t cur;
    cur = '{x: x_a, y: y_a, inb: inb_a,
            sop: sop_a, eop: eop_a};
    if (pend_done_a) begin
      chk("a_done_pulse", 32'(done_a), 32'd1);
      pend_done_a = 0;
    end
    if (stall_a) begin
      chk("a_stall_valid", 32'(valid_a), 32'd1);
      chk("a_stall_hold", 32'(cur == held_a), 32'd1);
    end
    if (valid_a && ready_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_pixel", 32'd1, 32'd0);
      end else begin
        cmp_pix("a_pix", cur, qa.pop_front());
      end
      cap_a[pop_a % 256] = cur;
      pop_a++;
      if (eop_a) pend_done_a = 1;
    end
    stall_a = valid_a && !ready_a && !reset;
    held_a = cur;
    if (done_a) done_cnt_a++;
  end

  // Monitor for the 16x4 instance.
  always @(negedge clk) begin
    exp_t cur;
    cur = '{x: x_b, y: y_b, inb: inb_b,
            sop: sop_b, eop: eop_b};
    if (pend_done_b) begin
      chk("b_done_pulse", 32'(done_b), 32'd1);
      pend_done_b = 0;
    end
    if (stall_b) begin
      chk("b_stall_valid", 32'(valid_b), 32'd1);
      chk("b_stall_hold", 32'(cur == held_b), 32'd1);
    end
    if (valid_b && ready_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_pixel", 32'd1, 32'd0);
      end else begin
        cmp_pix("b_pix", cur, qb.pop_front());
      end
      cap_b[pop_b % 256] = cur;
      pop_b++;
      if (eop_b) pend_done_b = 1;
    end
    stall_b = valid_b && !ready_b && !reset;
    held_b = cur;
    if (done_b) done_cnt_b++;
  end

  // Random 30% ready for the backpressure run.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_b) ready_b = ($urandom_range(0, 9) < 3);
    end
  end

  task automatic load_coefs(input int base,
                            input logic [31:0] ca, cb, ctx,
                            input logic [31:0] cc, cd, cty);
    mem[base + 0] = ca;
    mem[base + 1] = cb;
    mem[base + 2] = ctx;
    mem[base + 3] = cc;
    mem[base + 4] = cd;
    mem[base + 5] = cty;
  endtask

  // Reference mapping by direct multiply-accumulate.
  task automatic push_frame(input bit sel,
                            input logic [31:0] ca, cb, ctx,
                            input logic [31:0] cc, cd, cty,
                            input int w, input int h,
                            input int sw, input int sh);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        exp_t e;
        int   xi, yi;
        e.x = ca * 32'(c) + cb * 32'(r) + ctx;
        e.y = cc * 32'(c) + cd * 32'(r) + cty;
        xi = int'($signed(e.x[31:16]));
        yi = int'($signed(e.y[31:16]));
        e.inb = (xi >= 0) && (xi < sw) &&
                (yi >= 0) && (yi < sh);
        e.sop = (c == 0) && (r == 0);
        e.eop = (c == w - 1) && (r == h - 1);
        if (sel) qb.push_back(e);
        else qa.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input bit sel,
                             input bit chk_lat);
    int lat;
    @(posedge clk);
    #1;
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_after_start",
        32'(sel ? busy_b : busy_a), 32'd1);
    if (chk_lat) begin
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (valid_a) begin
          lat = i;
          break;
        end
      end
      chk("first_valid_latency", 32'(lat), 32'd9);
    end
  endtask

  task automatic wait_idle(input bit sel, input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (sel ? (!busy_b && qb.size() == 0)
              : (!busy_a && qa.size() == 0)) begin
        ok = 1;
        break;
      end
    end
    chk("frame_completes", 32'(ok), 32'd1);
  endtask

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] NEG1 = 32'hFFFF_0000;

  initial begin
    int base, dc, mism;
    bit hit;

    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dc, mism;
    bit hit;

    for (int i = 0; i < 1024; i++) mem[i] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_cs", 32'(cs_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_x", x_a, 32'd0);
    chk("rst_y", y_a, 32'd0);
    chk("rst_sop_eop", 32'({sop_a, eop_a}), 32'd0);
    reset = 1'b0;

    // Identity, 4x2.
    base = pop_a;
    dc = done_cnt_a;
    load_coefs(0, ONE, 0, 0, 0, ONE, 0);
    push_frame(0, ONE, 0, 0, 0, ONE, 0, 4, 2, 4, 2);
    start_frame(0, 1);
    wait_idle(0, 100);
    chk("id_count", 32'(pop_a - base), 32'd8);
    chk("id_x0", cap_a[base + 0].x, 32'h0);
    chk("id_x1", cap_a[base + 1].x, 32'h10000);
    chk("id_x2", cap_a[base + 2].x, 32'h20000);
    chk("id_x3", cap_a[base + 3].x, 32'h30000);
    chk("id_row1_y", cap_a[base + 4].y, 32'h10000);
    chk("id_row1_x", cap_a[base + 4].x, 32'h0);
    chk("id_sop0", 32'(cap_a[base + 0].sop), 32'd1);
    chk("id_eop7", 32'(cap_a[base + 7].eop), 32'd1);
    chk("id_done_once", 32'(done_cnt_a - dc), 32'd1);

    // Translation by -1 and bounds.
    base = pop_a;
    load_coefs(0, ONE, 0, NEG1, 0, ONE, 0);
    push_frame(0, ONE, 0, NEG1, 0, ONE, 0, 4, 2, 4, 2);
    start_frame(0, 0);
    wait_idle(0, 100);
    chk("tr_x0", cap_a[base + 0].x, 32'hFFFF0000);
    chk("tr_inb0", 32'(cap_a[base + 0].inb), 32'd0);
    chk("tr_x1", cap_a[base + 1].x, 32'h0);
    chk("tr_inb1", 32'(cap_a[base + 1].inb), 32'd1);

    // Scale and shear.
    base = pop_a;
    load_coefs(0, 32'h8000, 32'h4000, 0,
               0, 32'h20000, 0);
    push_frame(0, 32'h8000, 32'h4000, 0,
               0, 32'h20000, 0, 4, 2, 4, 2);
    start_frame(0, 0);
    wait_idle(0, 100);
    chk("sc_x_c2r1", cap_a[base + 6].x, 32'h00014000);
    chk("sc_y_c2r1", cap_a[base + 6].y, 32'h00020000);

    // Mid-frame start and RAM write are both ignored.
    base = pop_a;
    dc = done_cnt_a;
    load_coefs(0, ONE, 0, 32'h20000, 0, ONE, 0);
    push_frame(0, ONE, 0, 32'h20000, 0, ONE, 0,
               4, 2, 4, 2);
    start_frame(0, 0);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (pop_a >= base + 3) begin
        hit = 1;
        break;
      end
    end
    chk("rb_reach_run", 32'(hit), 32'd1);
    start_a = 1'b1;
    mem[0] = 32'h0007_0000;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_idle(0, 100);
    repeat (12) @(posedge clk);
    #1;
    chk("rb_no_restart", 32'(busy_a), 32'd0);
    chk("rb_count", 32'(pop_a - base), 32'd8);
    chk("rb_done_once", 32'(done_cnt_a - dc), 32'd1);
    chk("rb_x_last", cap_a[base + 7].x, 32'h50000);

    // Reset while pixel 5 is presented.
    base = pop_a;
    load_coefs(0, ONE, 0, 0, 0, ONE, 0);
    push_frame(0, ONE, 0, 0, 0, ONE, 0, 4, 2, 4, 2);
    start_frame(0, 0);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (pop_a >= base + 5) begin
        hit = 1;
        break;
      end
    end
    chk("rs_reach_px5", 32'(hit), 32'd1);
    chk("rs_px5_valid", 32'(valid_a), 32'd1);
    ready_a = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rs_valid", 32'(valid_a), 32'd0);
    chk("rs_busy", 32'(busy_a), 32'd0);
    chk("rs_cs", 32'(cs_a), 32'd0);
    chk("rs_x", x_a, 32'd0);
    qa.delete();
    ready_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rs_stays_idle", 32'(busy_a), 32'd0);
    base = pop_a;
    push_frame(0, ONE, 0, 0, 0, ONE, 0, 4, 2, 4, 2);
    start_frame(0, 1);
    wait_idle(0, 100);
    chk("rs_full_frame", 32'(pop_a - base), 32'd8);
    chk("rs_sop0", 32'(cap_a[base].sop), 32'd1);

    // 16x4 reference run, then 30% ready.
    load_coefs(16, 32'h18000, 32'hFFFF8000, 32'h123,
               32'h100, 32'h10000, 32'hFFFE0000);
    base = pop_b;
    push_frame(1, 32'h18000, 32'hFFFF8000, 32'h123,
               32'h100, 32'h10000, 32'hFFFE0000,
               16, 4, 640, 480);
    start_frame(1, 0);
    wait_idle(1, 400);
    chk("bp_ref_count", 32'(pop_b - base), 32'd64);
    chk("bp_x_last", cap_b[base + 63].x, 32'h150123);
    chk("bp_y_last", cap_b[base + 63].y, 32'h10F00);
    chk("bp_x0", cap_b[base].x, 32'h123);

    push_frame(1, 32'h18000, 32'hFFFF8000, 32'h123,
               32'h100, 32'h10000, 32'hFFFE0000,
               16, 4, 640, 480);
    rand_b = 1;
    start_frame(1, 0);
    wait_idle(1, 3000);
    rand_b = 0;
    @(posedge clk);
    #1;
    ready_b = 1'b1;
    chk("bp_handshakes", 32'(pop_b - base), 32'd128);
    mism = 0;
    for (int i = 0; i < 64; i++) begin
      if (cap_b[base + i] != cap_b[base + 64 + i])
        mism++;
    end
    chk("bp_same_sequence", 32'(mism), 32'd0);
    chk("bp_done_total", 32'(done_cnt_b), 32'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
